// File: rtl/ps2_keyboard_tx.sv
// Device-side PS/2 keyboard transmitter: FIFO-queued scan codes sent as 11-bit frames on ps2_clk/ps2_data.
// Optional macro PS2_TX_ERR_INJECT_EN adds err_inject_i, which inverts the parity bit of the popped frame.
module ps2_keyboard_tx #(
  parameter int HALF_PERIOD = 50,
  parameter int GAP_CYCLES  = 200,
  parameter int FIFO_DEPTH  = 8,
  parameter int PTR_W       = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [7:0]       din_i,
  input  logic             din_valid_i,
  output logic             din_ready_o,
  output logic             ps2_clk_o,
  output logic             ps2_data_o,
  output logic             busy_o,
  output logic [PTR_W:0]   fifo_count_o
`ifdef PS2_TX_ERR_INJECT_EN
  ,
  input  logic             err_inject_i
`endif
);

  localparam int HC_W = $clog2(HALF_PERIOD);
  localparam int GC_W = $clog2(GAP_CYCLES + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, GAP = 2'd2} state_e;

  state_e            state_q, state_d;
  logic [3:0]        bit_q, bit_d;
  logic [HC_W-1:0]   half_q, half_d;
  logic              phase_q, phase_d;
  logic [GC_W-1:0]   gap_q, gap_d;
  logic [10:0]       frame_q, frame_d;
  logic              ps2_clk_q, ps2_clk_d;
  logic              ps2_data_q, ps2_data_d;
  logic              busy_q, busy_d;

  logic [7:0]        mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]    count_q;
  logic              push_s, pop_s, inj_s;
  logic [7:0]        head_s;

  assign din_ready_o  = (count_q != (PTR_W+1)'(FIFO_DEPTH));
  assign push_s       = din_valid_i & din_ready_o;
  assign pop_s        = (state_q == IDLE) && (count_q != '0);
  assign head_s       = mem_q[rd_ptr_q];
  assign fifo_count_o = count_q;
  assign ps2_clk_o    = ps2_clk_q;
  assign ps2_data_o   = ps2_data_q;
  assign busy_o       = busy_q;

`ifdef PS2_TX_ERR_INJECT_EN
  assign inj_s = err_inject_i;
`else
  assign inj_s = 1'b0;
`endif

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_s) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      bit_q      <= 4'd0;
      half_q     <= '0;
      phase_q    <= 1'b0;
      gap_q      <= '0;
      frame_q    <= 11'h7FF;
      ps2_clk_q  <= 1'b1;
      ps2_data_q <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_q      <= bit_d;
      half_q     <= half_d;
      phase_q    <= phase_d;
      gap_q      <= gap_d;
      frame_q    <= frame_d;
      ps2_clk_q  <= ps2_clk_d;
      ps2_data_q <= ps2_data_d;
      busy_q     <= busy_d;
    end
  end

  // Each slot: phase 0 is the clock-high half, phase 1 the clock-low half.
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    half_d  = half_q;
    phase_d = phase_q;
    gap_d   = gap_q;
    frame_d = frame_q;
    case (state_q)
      IDLE: begin
        if (pop_s) begin
          state_d = SHIFT;
          bit_d   = 4'd0;
          half_d  = '0;
          phase_d = 1'b0;
          frame_d = {1'b1, (~^head_s) ^ inj_s, head_s, 1'b0};
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        if (half_q == HC_W'(HALF_PERIOD - 1)) begin
          half_d = '0;
          if (phase_q) begin
            phase_d = 1'b0;
            if (bit_q == 4'd10) begin
              state_d = GAP;
              gap_d   = '0;
            end else begin
              bit_d = bit_q + 4'd1;
            end
          end else begin
            phase_d = 1'b1;
          end
        end else begin
          half_d = half_q + HC_W'(1);
        end
      end
      GAP: begin
        if (gap_q == GC_W'(GAP_CYCLES - 1)) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q + GC_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    ps2_clk_d  = 1'b1;
    ps2_data_d = 1'b1;
    if (state_q == SHIFT) begin
      ps2_clk_d  = ~phase_q;
      ps2_data_d = frame_q[bit_q];
    end else begin
      ps2_clk_d  = 1'b1;
      ps2_data_d = 1'b1;
    end
    busy_d = (state_d != IDLE);
  end

endmodule

// File: tb/tb_ps2_keyboard_tx.sv
// Self-checking bench for ps2_keyboard_tx: directed stimulus, scoreboard queue, frame decoder on ps2 lines.
module tb_ps2_keyboard_tx;
  localparam int HP  = 4;
  localparam int GAP = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din = 8'h00;
  logic       din_valid = 1'b0;
  logic       din_ready, ps2_clk, ps2_data, busy;
  logic [3:0] fifo_count;
  logic       err_inj = 1'b0;

  ps2_keyboard_tx #(.HALF_PERIOD(HP), .GAP_CYCLES(GAP), .FIFO_DEPTH(8), .PTR_W(3)) dut (
    .clk_i(clk), .rst_i(rst), .din_i(din), .din_valid_i(din_valid), .din_ready_o(din_ready),
    .ps2_clk_o(ps2_clk), .ps2_data_o(ps2_data), .busy_o(busy), .fifo_count_o(fifo_count)
`ifdef PS2_TX_ERR_INJECT_EN
    , .err_inject_i(err_inj)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [8:0] sb[$];
  int frames = 0;
  int nbits = 0;
  int low_cnt = 0;
  int hi_cnt = 0;
  int last_gap = 0;
  logic skip = 1'b1;
  logic prev_clk = 1'b1, prev_data = 1'b1, low_data = 1'b1;
  logic [10:0] shift = 11'h000;
  logic saw_full = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Decode frames at ps2_clk falls and compare against the scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      nbits = 0; low_cnt = 0; hi_cnt = 0; skip = 1'b1;
    end else begin
      if (prev_clk && ps2_clk && prev_data && !ps2_data) last_gap = hi_cnt;
      if (ps2_clk && ps2_data) hi_cnt++; else hi_cnt = 0;
      if (prev_clk && !ps2_clk) begin
        shift[nbits] = ps2_data;
        nbits++;
        low_data = ps2_data;
        low_cnt = 1;
        if (nbits == 11) begin
          logic [8:0] e;
          nbits = 0;
          frames++;
          if (sb.size() == 0) begin
            check("unexpected_frame", {21'd0, shift}, 32'hFFFFFFFF);
          end else begin
            e = sb.pop_front();
            check("start_bit", {31'd0, shift[0]}, 32'd0);
            check("data_byte", {24'd0, shift[8:1]}, {24'd0, e[7:0]});
            check("parity_bit", {31'd0, shift[9]}, {31'd0, e[8]});
            check("stop_bit", {31'd0, shift[10]}, 32'd1);
          end
        end
      end else if (!ps2_clk) begin
        low_cnt++;
        check("data_stable_low", {31'd0, ps2_data}, {31'd0, low_data});
      end else if (!prev_clk && ps2_clk) begin
        if (!skip) check("low_len", low_cnt, HP);
        skip = 1'b0;
      end
    end
    prev_clk = ps2_clk;
    prev_data = ps2_data;
  end

  task automatic push(input logic [7:0] code, input logic inj);
    int n = 0;
    din = code;
    din_valid = 1'b1;
    while (!din_ready && n < 1000) begin
      saw_full = 1'b1;
      check("full_count", {28'd0, fifo_count}, 32'd8);
      @(negedge clk);
      n++;
    end
    check("ready_timeout", {31'd0, (n < 1000)}, 32'd1);
    sb.push_back({(~^code) ^ inj, code});
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    din_valid = 1'b0;
    while ((busy || fifo_count != 4'd0 || sb.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("done_timeout", {31'd0, (n < budget)}, 32'd1);
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_lines", {30'd0, ps2_clk, ps2_data}, 32'd3);
  endtask

  initial begin
    int f0;
    int n;
    // 1: reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_clk", {31'd0, ps2_clk}, 32'd1);
    check("rst_data", {31'd0, ps2_data}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_count", {28'd0, fifo_count}, 32'd0);
    check("rst_ready", {31'd0, din_ready}, 32'd1);
    rst = 1'b0;
    @(negedge clk);

    // 2: single code, start-bit latency
    f0 = frames;
    push(8'h1C, 1'b0);
    din_valid = 1'b0;
    check("lat_pop_data", {31'd0, ps2_data}, 32'd1);
    @(negedge clk);
    check("lat_busy", {31'd0, busy}, 32'd1);
    check("lat_start_pre", {31'd0, ps2_data}, 32'd1);
    @(negedge clk);
    check("lat_start", {31'd0, ps2_data}, 32'd0);
    wait_done(400);
    check("frames_t2", frames, f0 + 1);

    // 3: back-to-back codes and inter-frame gap
    f0 = frames;
    push(8'hF0, 1'b0);
    push(8'h1C, 1'b0);
    wait_done(800);
    check("frames_t3", frames, f0 + 2);
    check("gap_len", last_gap, GAP + 1);

    // 4: twelve codes with valid held, FIFO fills and wraps
    f0 = frames;
    saw_full = 1'b0;
    for (int i = 1; i <= 12; i++) push(i[7:0], 1'b0);
    wait_done(3000);
    check("frames_t4", frames, f0 + 12);
    check("saw_full", {31'd0, saw_full}, 32'd1);

    // 5: reset mid-frame with codes queued
    push(8'h55, 1'b0);
    push(8'h11, 1'b0);
    push(8'h22, 1'b0);
    din_valid = 1'b0;
    n = 0;
    while (nbits != 5 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("bit4_timeout", {31'd0, (n < 400)}, 32'd1);
    rst = 1'b1;
    sb.delete();
    @(posedge clk);
    @(negedge clk);
    check("mrst_lines", {30'd0, ps2_clk, ps2_data}, 32'd3);
    check("mrst_count", {28'd0, fifo_count}, 32'd0);
    check("mrst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    f0 = frames;
    push(8'h29, 1'b0);
    check("par_29_model", {31'd0, sb[0][8]}, 32'd0);
    wait_done(400);
    check("frames_t5", frames, f0 + 1);

`ifdef PS2_TX_ERR_INJECT_EN
    // 6: parity inversion on one frame only
    f0 = frames;
    err_inj = 1'b1;
    push(8'h1C, 1'b1);
    din_valid = 1'b0;
    @(negedge clk);
    err_inj = 1'b0;
    wait_done(400);
    push(8'h1C, 1'b0);
    wait_done(400);
    check("frames_t6", frames, f0 + 2);
`endif

    check("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
